// File: rtl/cmd_rx_fsm.sv
// cmd_rx_fsm: byte-stream command front-end. Parses HDR/LEN_LO/LEN_HI/payload
// frames, writes CUM payload elements into the vector buffer, issues a one-cycle
// cmd_ready to the core FSM and blocks until data_ready.
// Optional inter-byte timeout is enabled with `define CMD_TIMEOUT_EN.
module cmd_rx_fsm #(
   parameter int ELEM_BYTES  = 4,
   parameter int MAX_LEN     = 1024,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic                    buf_we,
   output logic [ADDR_W-1:0]       buf_addr,
   output logic [8*ELEM_BYTES-1:0] buf_wdata,
   output logic [ADDR_W:0]         vec_len,
   output logic                    cmd_ready,
   output logic                    out_mode,
   input  logic                    data_ready,
   output logic                    err
);

   localparam int BI_W = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
   localparam logic [BI_W-1:0]   LAST_BI = BI_W'(ELEM_BYTES - 1);
   localparam logic [15:0]       MAX_L16 = 16'(MAX_LEN);
   localparam logic [ADDR_W:0]   VL_ONE  = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      S_HDR, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_ISSUE, S_WAIT
   } state_t;

   state_t                  state_q, state_d;
   logic                    rx_ready_q, rx_ready_d;
   logic                    buf_we_q, buf_we_d;
   logic [ADDR_W-1:0]       buf_addr_q, buf_addr_d;
   logic [8*ELEM_BYTES-1:0] buf_wdata_q, buf_wdata_d;
   logic [ADDR_W:0]         vec_len_q, vec_len_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    out_mode_q, out_mode_d;
   logic                    err_q, err_d;
   logic [7:0]              len_lo_q, len_lo_d;
   logic [ADDR_W-1:0]       elem_idx_q, elem_idx_d;
   logic [BI_W-1:0]         byte_idx_q, byte_idx_d;
   logic [8*ELEM_BYTES-1:0] word_q, word_d;
   // set during the cycle the final element is written; holds off rx and then issues
   logic                    wr_done_q, wr_done_d;
   logic [15:0]             len16;
   logic                    acc;
`ifdef CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0]        tmo_q, tmo_d;
`endif

   assign acc = rx_valid && rx_ready_q;

   // next-state and registered-output computation
   always_comb begin
      state_d     = state_q;
      buf_we_d    = 1'b0;
      buf_addr_d  = buf_addr_q;
      buf_wdata_d = buf_wdata_q;
      vec_len_d   = vec_len_q;
      cmd_ready_d = 1'b0;
      out_mode_d  = out_mode_q;
      err_d       = 1'b0;
      len_lo_d    = len_lo_q;
      elem_idx_d  = elem_idx_q;
      byte_idx_d  = byte_idx_q;
      word_d      = word_q;
      wr_done_d   = 1'b0;
      len16       = {rx_data, len_lo_q};
      case (state_q)
         S_HDR: if (acc) begin
            out_mode_d = rx_data[7];
            if (rx_data[6:0] != 7'd0) err_d = 1'b1;
            else                      state_d = S_LEN_LO;
         end
         S_LEN_LO: if (acc) begin
            len_lo_d = rx_data;
            state_d  = S_LEN_HI;
         end
         S_LEN_HI: if (acc) begin
            if (len16 == 16'd0 || len16 > MAX_L16) begin
               err_d   = 1'b1;
               state_d = S_HDR;
            end else begin
               vec_len_d = len16[ADDR_W:0];
               if (out_mode_q) begin
                  state_d    = S_PAYLOAD;
                  elem_idx_d = '0;
                  byte_idx_d = '0;
                  word_d     = '0;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_PAYLOAD: begin
            if (wr_done_q) begin
               state_d = S_ISSUE;
            end else if (acc) begin
               word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
               if (byte_idx_q == LAST_BI) begin
                  buf_we_d    = 1'b1;
                  buf_addr_d  = elem_idx_q;
                  buf_wdata_d = word_d;
                  byte_idx_d  = '0;
                  elem_idx_d  = elem_idx_q + 1'b1;
                  if ({1'b0, elem_idx_q} == vec_len_q - VL_ONE) wr_done_d = 1'b1;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
               end
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (data_ready) state_d = S_HDR;
         default: state_d = S_HDR;
      endcase
`ifdef CMD_TIMEOUT_EN
      tmo_d = '0;
      if ((state_q == S_LEN_LO || state_q == S_LEN_HI || state_q == S_PAYLOAD) &&
          !acc && !wr_done_q) begin
         if (tmo_q == TMO_LAST) begin
            err_d     = 1'b1;
            state_d   = S_HDR;
            buf_we_d  = 1'b0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif
      cmd_ready_d = (state_d == S_ISSUE);
      rx_ready_d  = (state_d == S_HDR || state_d == S_LEN_LO || state_d == S_LEN_HI ||
                     state_d == S_PAYLOAD) && !wr_done_d;
   end

   // state and output registers; buffer contents are external and untouched here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HDR;
         rx_ready_q  <= 1'b0;
         buf_we_q    <= 1'b0;
         buf_addr_q  <= '0;
         buf_wdata_q <= '0;
         vec_len_q   <= '0;
         cmd_ready_q <= 1'b0;
         out_mode_q  <= 1'b0;
         err_q       <= 1'b0;
         len_lo_q    <= '0;
         elem_idx_q  <= '0;
         byte_idx_q  <= '0;
         word_q      <= '0;
         wr_done_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rx_ready_q  <= rx_ready_d;
         buf_we_q    <= buf_we_d;
         buf_addr_q  <= buf_addr_d;
         buf_wdata_q <= buf_wdata_d;
         vec_len_q   <= vec_len_d;
         cmd_ready_q <= cmd_ready_d;
         out_mode_q  <= out_mode_d;
         err_q       <= err_d;
         len_lo_q    <= len_lo_d;
         elem_idx_q  <= elem_idx_d;
         byte_idx_q  <= byte_idx_d;
         word_q      <= word_d;
         wr_done_q   <= wr_done_d;
`ifdef CMD_TIMEOUT_EN
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign rx_ready  = rx_ready_q;
   assign buf_we    = buf_we_q;
   assign buf_addr  = buf_addr_q;
   assign buf_wdata = buf_wdata_q;
   assign vec_len   = vec_len_q;
   assign cmd_ready = cmd_ready_q;
   assign out_mode  = out_mode_q;
   assign err       = err_q;

endmodule

// File: tb/tb_cmd_rx_fsm.sv
// tb_cmd_rx_fsm: directed frames against a frame-level expectation model
// (expected writes / commands / errors), plus literal timing checks.
module tb_cmd_rx_fsm;
`ifdef CMD_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 100000;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        buf_we;
   logic [9:0]  buf_addr;
   logic [31:0] buf_wdata;
   logic [10:0] vec_len;
   logic        cmd_ready;
   logic        out_mode;
   logic        data_ready;
   logic        err;

   cmd_rx_fsm #(.ELEM_BYTES(4), .MAX_LEN(1024), .ADDR_W(10), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata), .vec_len(vec_len),
      .cmd_ready(cmd_ready), .out_mode(out_mode), .data_ready(data_ready), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [9:0] a; logic [31:0] d; } wr_t;
   typedef struct { logic m; logic [10:0] l; } cmd_t;

   wr_t        exp_wr[$];
   cmd_t       exp_cmd[$];
   int         exp_err_n = 0;
   logic [7:0] fr[$];
   int         ntest = 0;
   int         nfail = 0;
   int         bubbles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame-level model: what a whole frame must produce, from the frame rules
   task automatic model_frame();
      logic [7:0]  hdr;
      logic [15:0] len;
      hdr = fr[0];
      if (hdr[6:0] != 7'd0) begin exp_err_n++; return; end
      len = {fr[2], fr[1]};
      if (len == 16'd0 || len > 16'd1024) begin exp_err_n++; return; end
      if (hdr[7]) begin
         for (int e = 0; e < int'(len); e++) begin
            wr_t w;
            w.a = 10'(e);
            w.d = {fr[3+4*e+3], fr[3+4*e+2], fr[3+4*e+1], fr[3+4*e]};
            exp_wr.push_back(w);
         end
      end
      exp_cmd.push_back('{m: hdr[7], l: len[10:0]});
   endtask

   // compare process: every write / issue / error must match the model, in order
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (buf_we === 1'b1) begin
            if (exp_wr.size() == 0) chk("unexpected_buf_we", 32'd1, 32'd0);
            else begin
               wr_t w;
               w = exp_wr.pop_front();
               chk("buf_addr", 32'(buf_addr), 32'(w.a));
               chk("buf_wdata", buf_wdata, w.d);
            end
         end
         if (cmd_ready === 1'b1) begin
            if (exp_cmd.size() == 0) chk("unexpected_cmd_ready", 32'd1, 32'd0);
            else begin
               cmd_t c;
               c = exp_cmd.pop_front();
               chk("out_mode", 32'(out_mode), 32'(c.m));
               chk("vec_len", 32'(vec_len), 32'(c.l));
            end
         end
         if (err === 1'b1) begin
            if (exp_err_n == 0) chk("unexpected_err", 32'd1, 32'd0);
            else exp_err_n--;
         end
      end
   end

   // called at a negedge; returns at the negedge following the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      bubbles += n;
      if (n >= 1000) chk("rx_ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic send_range(input int s, input int e);
      for (int i = s; i < e; i++) send_byte(fr[i]);
      rx_valid = 1'b0;
   endtask

   task automatic release_done();
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      chk("rx_ready_after_done", 32'(rx_ready), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
      chk({tag, "_buf_we"}, 32'(buf_we), 32'd0);
      chk({tag, "_buf_addr"}, 32'(buf_addr), 32'd0);
      chk({tag, "_buf_wdata"}, buf_wdata, 32'd0);
      chk({tag, "_vec_len"}, 32'(vec_len), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_out_mode"}, 32'(out_mode), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; data_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("rx_ready_post_reset", 32'(rx_ready), 32'd1);

      // READ len 5, then WAIT_DONE backpressure with 0x80 held
      fr = '{8'h00, 8'h05, 8'h00};
      model_frame();
      send_range(0, 3);
      chk("read_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("read_out_mode", 32'(out_mode), 32'd0);
      chk("read_vec_len", 32'(vec_len), 32'd5);
      chk("read_rx_ready_issue", 32'(rx_ready), 32'd0);
      chk("read_no_we", 32'(buf_we), 32'd0);
      @(negedge clk);
      chk("read_cmd_ready_1cyc", 32'(cmd_ready), 32'd0);
      rx_valid = 1'b1; rx_data = 8'h80;
      repeat (3) @(negedge clk);
      chk("wait_rx_ready", 32'(rx_ready), 32'd0);
      chk("wait_not_consumed", 32'(out_mode), 32'd0);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      chk("done_rx_ready", 32'(rx_ready), 32'd1);
      chk("done_not_yet_consumed", 32'(out_mode), 32'd0);
      @(negedge clk);
      chk("held_byte_accepted", 32'(out_mode), 32'd1);

      // CUM len 2, continuing from the held header byte
      fr = '{8'h80, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      model_frame();
      bubbles = 0;
      send_range(1, fr.size());
      chk("cum_no_bubbles", 32'(bubbles), 32'd0);
      chk("cum_we", 32'(buf_we), 32'd1);
      chk("cum_addr1", 32'(buf_addr), 32'd1);
      chk("cum_data1", buf_wdata, 32'hDDCCBBAA);
      chk("cum_cmd_not_yet", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("cum_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("cum_out_mode", 32'(out_mode), 32'd1);
      chk("cum_vec_len", 32'(vec_len), 32'd2);
      chk("cum_we_1cyc", 32'(buf_we), 32'd0);
      @(negedge clk);
      release_done();

      // bad header: err, stays in HDR so the next byte is a header
      fr = '{8'h81};
      model_frame();
      send_range(0, 1);
      chk("badhdr_err", 32'(err), 32'd1);
      chk("badhdr_rx_ready", 32'(rx_ready), 32'd1);
      @(negedge clk);
      chk("badhdr_err_1cyc", 32'(err), 32'd0);
      fr = '{8'h00, 8'h04, 8'h00};
      model_frame();
      send_range(0, 3);
      chk("after_bad_cmd", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      release_done();

      // len 0 and len 1025
      fr = '{8'h80, 8'h00, 8'h00};
      model_frame();
      send_range(0, 3);
      chk("len0_err", 32'(err), 32'd1);
      chk("len0_rx_ready", 32'(rx_ready), 32'd1);
      fr = '{8'h80, 8'h01, 8'h04};
      model_frame();
      send_range(0, 3);
      chk("len1025_err", 32'(err), 32'd1);
      repeat (3) @(negedge clk);

      // READ len 1024 (max); data_ready during ISSUE is ignored
      fr = '{8'h00, 8'h00, 8'h04};
      model_frame();
      send_range(0, 3);
      chk("max_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("max_vec_len", 32'(vec_len), 32'd1024);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
      chk("issue_ignores_done", 32'(rx_ready), 32'd0);
      release_done();

      // 15-cycle stall after LEN_LO (data_ready ignored meanwhile), one CUM element
      fr = '{8'h80, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      model_frame();
      send_range(0, 2);
      data_ready = 1'b1;
      repeat (15) @(negedge clk);
      data_ready = 1'b0;
      chk("stall15_no_err", 32'(err), 32'd0);
`ifdef CMD_TIMEOUT_EN
      send_range(2, fr.size());
`else
      send_range(2, 4);
      repeat (40) @(negedge clk);
      send_range(4, fr.size());
`endif
      chk("stall_we", 32'(buf_we), 32'd1);
      chk("stall_data", buf_wdata, 32'h04030201);
      @(negedge clk);
      chk("stall_cmd", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      release_done();

`ifdef CMD_TIMEOUT_EN
      // 16-cycle stall after LEN_LO times out
      fr = '{8'h00, 8'h03};
      exp_err_n++;
      send_range(0, 2);
      repeat (15) @(negedge clk);
      chk("tmo_not_yet", 32'(err), 32'd0);
      @(negedge clk);
      chk("tmo_err", 32'(err), 32'd1);
      chk("tmo_hdr", 32'(rx_ready), 32'd1);
      @(negedge clk);
      fr = '{8'h00, 8'h02, 8'h00};
      model_frame();
      send_range(0, 3);
      chk("tmo_recover_cmd", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      release_done();
`endif

      // reset after 3 payload bytes drops the command
      fr = '{8'h80, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      send_range(0, fr.size());
      rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      fr = '{8'h00, 8'h03, 8'h00};
      model_frame();
      send_range(0, 3);
      chk("postrst_cmd", 32'(cmd_ready), 32'd1);
      chk("postrst_len", 32'(vec_len), 32'd3);
      @(negedge clk);
      release_done();

      repeat (3) @(negedge clk);
      chk("pending_writes", 32'(exp_wr.size()), 32'd0);
      chk("pending_cmds", 32'(exp_cmd.size()), 32'd0);
      chk("pending_errs", 32'(exp_err_n), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
